// File: rtl/md_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
// The E stage drives operands and op; the unit returns busy, hazard and HI/LO.
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             md_hazard;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, md_hazard, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, md_hazard, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at accept time and held pending until the busy count expires.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic clr,
    md_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, pend_hi, pend_lo;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] ax, bx, prod;
    logic [WIDTH-1:0]   dvd, dvs, dvs_safe, uq, ur;
    logic               busy, is_mul, is_div, is_signed, accept;
    logic               a_neg, b_neg;

    assign busy      = (cnt != '0);
    assign is_mul    = (md.op == OP_MULT) || (md.op == OP_MULTU);
    assign is_div    = (md.op == OP_DIV) || (md.op == OP_DIVU);
    assign is_signed = (md.op == OP_MULT) || (md.op == OP_DIV);
    assign accept    = md.start && !busy && (is_mul || is_div);
    assign a_neg     = is_signed && md.a[WIDTH-1];
    assign b_neg     = is_signed && md.b[WIDTH-1];

    assign md.busy      = busy;
    assign md.md_hazard = busy || (md.start && (is_mul || is_div));
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

    always_comb begin
        ax       = {{WIDTH{a_neg}}, md.a};
        bx       = {{WIDTH{b_neg}}, md.b};
        prod     = ax * bx;
        dvd      = a_neg ? -md.a : md.a;
        dvs      = b_neg ? -md.b : md.b;
        dvs_safe = (dvs == '0) ? WIDTH'(1) : dvs;
        uq       = dvd / dvs_safe;
        ur       = dvd % dvs_safe;
        res_hi   = '0;
        res_lo   = '0;
        unique case (1'b1)
            is_mul: {res_hi, res_lo} = prod;
            is_div: begin
                // MIN / -1 wraps naturally: |MIN| / 1 negated is MIN again
                if (md.b == '0) begin
                    res_lo = '1;
                    res_hi = md.a;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -uq : uq;
                    res_hi = a_neg ? -ur : ur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (md.start) begin
            if (accept) begin
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (md.op == OP_MTHI) hi_q <= md.a;
            if (md.op == OP_MTLO) lo_q <= md.a;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit.
// A behavioural HI/LO model predicts every result.
module tb_muldiv_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_if #(.WIDTH(32)) mif ();

    muldiv_unit #(
        .WIDTH(32),
        .MULT_CYCLES(MC),
        .DIV_CYCLES(DC)
    ) dut (
        .clk(clk),
        .clr(clr),
        .md(mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
        longint   sp;
        logic [63:0] up;
        int       sx, sy;
        sx = x;
        sy = y;
        case (o)
            3'd1: begin
                sp = longint'(sx) * longint'(sy);
                {exp_hi, exp_lo} = sp;
            end
            3'd2: begin
                up = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = up;
            end
            3'd3: begin
                if (y == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    exp_lo = x;
                    exp_hi = 0;
                end else begin
                    exp_lo = sx / sy;
                    exp_hi = sx % sy;
                end
            end
            3'd4: begin
                if (y == 0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = x;
                end else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                end
            end
            3'd5: exp_hi = x;
            3'd6: exp_lo = x;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit poke);
        bit md;
        int n;
        md = (o >= 3'd1 && o <= 3'd4);
        n  = (o <= 3'd2) ? MC : DC;
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = o;
        mif.a     = x;
        mif.b     = y;
        #1;
        check("hazard_issue", 32'(mif.md_hazard), 32'(md));
        model(o, x, y);
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.op    = 3'd0;
        if (md) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                check("busy_run", 32'(mif.busy), 32'd1);
                if (poke && i == 3) begin
                    mif.start = 1'b1;
                    mif.op    = 3'd6;
                    mif.a     = 32'hABCD;
                    #1;
                    check("hazard_busy", 32'(mif.md_hazard), 32'd1);
                    @(posedge clk);
                    #1;
                    mif.start = 1'b0;
                    mif.op    = 3'd0;
                end
            end
        end
        @(negedge clk);
        check("busy_done", 32'(mif.busy), 32'd0);
        check("hazard_idle", 32'(mif.md_hazard), 32'd0);
        check("hi", mif.hi, exp_hi);
        check("lo", mif.lo, exp_lo);
    endtask

    initial begin
        mif.start = 1'b0;
        mif.op    = 3'd0;
        mif.a     = '0;
        mif.b     = '0;
        #12;
        check("rst_hi", mif.hi, 32'd0);
        check("rst_lo", mif.lo, 32'd0);
        check("rst_busy", 32'(mif.busy), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'd7, 32'd2, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h1234, 32'd0, 1);
        run_op(3'd5, 32'h55, 32'd0, 0);
        run_op(3'd0, 32'h77, 32'd1, 0);
        run_op(3'd7, 32'h77, 32'd1, 0);
        run_op(3'd3, 32'd100, 32'd0, 0);
        run_op(3'd6, 32'h1111, 32'd0, 0);

        // abort a divide mid-flight
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 3'd3;
        mif.a     = 32'd100;
        mif.b     = 32'd7;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.op    = 3'd0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        #1;
        check("abort_hi", mif.hi, 32'd0);
        check("abort_lo", mif.lo, 32'd0);
        check("abort_busy", 32'(mif.busy), 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        clr = 1'b0;
        repeat (DC + 2) @(negedge clk);
        check("post_abort_hi", mif.hi, 32'd0);
        check("post_abort_lo", mif.lo, 32'd0);
        check("post_abort_busy", 32'(mif.busy), 32'd0);

        for (int k = 0; k < 150; k++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 0;
                1: begin
                    x = 32'h8000_0000;
                    y = 32'hFFFF_FFFF;
                end
                2: y = 32'($urandom_range(1, 20));
                3: y = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(o, x, y, ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage.
- Holds busy for a configurable latency per operation class, then commits the result to HI/LO.
- Exports a hazard signal so the D-stage stall logic can hold any HI/LO-dependent instruction (mfhi/mflo/md ops) while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO register width
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-high reset
start  in  1  op valid this cycle (E-stage instruction is an md op, not flushed)
op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  in  WIDTH  rt operand (divisor / multiplier)
busy  out  1  multi-cycle op in flight
md_hazard  out  1  busy | (start & op in 1..4); drives D-stage stall
hi  out  WIDTH  committed HI
lo  out  WIDTH  committed LO

Behaviour:
- Reset (clr=1, asynchronous): hi=0, lo=0, counter=0, busy=0, pending result discarded. Reset mid-operation aborts with no commit.
- Accept: start=1, busy=0, op in 1..4. On that edge:
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - operands, or the precomputed result, are latched into pending HI/LO.
  - An iterative datapath is permitted if it finishes within the configured cycles.
- busy = (counter != 0). Counter decrements each cycle while nonzero.
- Commit: on the edge where counter goes 1->0, pending HI/LO are written to hi/lo.
- Latency: op accepted at edge T.
  - busy is high for exactly N cycles after T.
  - New hi/lo and busy=0 are visible in the same cycle, after edge T+N.
- MTHI/MTLO with start=1 and busy=0: hi (or lo) <= a on the next edge. No busy, zero latency. The other register is unchanged.
- Any start while busy=1, for any op, is ignored: no state change, running op unaffected. The hazard unit guarantees this never occurs in legal flow.
- op 0 or 7 with start=1: no effect.
- Arithmetic, 2*WIDTH product, HI = upper half, LO = lower half:
  - MULT: signed a*b.
  - MULTU: unsigned a*b.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Division by zero (b=0), DIV and DIVU: LO = all ones, HI = a.
- Signed overflow (a = most negative, b = -1): LO = a, HI = 0.
- hi/lo outputs are register outputs only; no bypass of the pending result.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. DIVU a=7, b=2 -> busy high 10 cycles; then lo=3, hi=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. Pulse MTLO a=0xABCD while busy=1 mid-op -> ignored; final lo = division result.
- MTHI a=0x55 with busy=0 -> hi=0x55 next cycle, busy stays 0, md_hazard=0. MULT issue cycle -> md_hazard=1 combinationally in that cycle.
- Start DIV, assert clr after 4 cycles -> hi=lo=0 and busy=0 immediately; no commit after clr releases.
